// File: rtl/lpm_fifo_dc_pkg.sv
// Shared definitions for the dual-clock FIFO read and write controllers.
// Holds the pointer-width rule and the Gray/binary conversion helpers.
package lpm_fifo_dc_pkg;

  // Pointers carry one bit more than the address so full and empty differ.
  localparam int PTR_EXTRA_BITS = 1;

  // Widest pointer the conversion helpers handle. Callers zero-extend their
  // pointer into this width and truncate the result back. Both conversions
  // are exact under zero-extension for any pointer up to this width.
  localparam int FUNC_W = 32;

  // Pointer width for a given address width.
  function automatic int ptr_width(input int widthu);
    return widthu + PTR_EXTRA_BITS;
  endfunction

  // Binary to Gray: each bit is the XOR of itself and the bit above it.
  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of every Gray bit at or above it.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b = '0;
    for (int i = 0; i < FUNC_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/lpm_fifo_dc_gray2bin.sv
// Combinational Gray-to-binary decoder (XOR prefix from the MSB down).
module lpm_fifo_dc_gray2bin #(
  parameter int width = 5
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  // Bit i of the binary value is the XOR of Gray bits [width-1:i].
  always_comb begin
    // NOTE: every output gets a default before the loop so no bit can hold
    // state from a previous evaluation and no latch is inferred.
    bin = '0;
    for (int i = 0; i < width; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/lpm_fifo_dc_rdside.sv
// Read-domain controller of the dual-clock FIFO.
// Decodes the synchronized Gray write pointer, owns the read pointer and
// produces registered empty/full/used status, the RAM read address/strobe
// and the Gray read pointer exported to the write domain.
// Optional checking: define LPM_FIFO_DC_RDSIDE_CHECK_EN to enable underflow
// and illegal-pointer detection on rderror (with status clamping).
module lpm_fifo_dc_rdside
  import lpm_fifo_dc_pkg::*;
#(
  parameter int lpm_widthu = 4
) (
  input  logic                                clock,
  input  logic                                sclr,
  input  logic                                rdreq,
  input  logic [ptr_width(lpm_widthu)-1:0]    wrptr_g,
  output logic                                rden,
  output logic [lpm_widthu-1:0]               rdaddr,
  output logic [ptr_width(lpm_widthu)-1:0]    rdptr_g,
  output logic [ptr_width(lpm_widthu)-1:0]    rdusedw,
  output logic                                rdempty,
  output logic                                rdfull,
  output logic                                rderror
);

  localparam int PTR_W = ptr_width(lpm_widthu);
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {lpm_widthu{1'b0}}};

  logic [PTR_W-1:0] rdptr_b;
  logic [PTR_W-1:0] wr_b;
  logic [PTR_W-1:0] wr_dec;
  logic [PTR_W-1:0] next_wr_b;
  logic [PTR_W-1:0] next_rdptr_b;
  logic [PTR_W-1:0] next_used;

  lpm_fifo_dc_gray2bin #(
    .width (PTR_W)
  ) u_wr_dec (
    .gray (wrptr_g),
    .bin  (wr_dec)
  );

  // The read strobe depends only on the registered empty flag, keeping the
  // synchronized write pointer out of the rden timing path.
  assign rden   = rdreq & ~rdempty & ~sclr;
  assign rdaddr = rdptr_b[lpm_widthu-1:0];

  // Next pointer values and the occupancy they imply after this edge.
  always_comb begin
    next_wr_b    = (wr_dec != wr_b) ? wr_dec : wr_b;
    next_rdptr_b = rdptr_b + PTR_W'(rden);
    next_used    = next_wr_b - next_rdptr_b;
  end

`ifdef LPM_FIFO_DC_RDSIDE_CHECK_EN
  logic overflow;
  logic underflow;

  // A legal write pointer can never lead the read pointer by more than depth.
  assign overflow  = next_used > DEPTH;
  assign underflow = rdreq & rdempty & ~sclr;
`endif

  // Pointer and status registers; sclr loads the empty state.
  always_ff @(posedge clock) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (sclr) begin
      rdptr_b <= '0;
      wr_b    <= '0;
      rdptr_g <= '0;
      rdusedw <= '0;
      rdempty <= 1'b1;
      rdfull  <= 1'b0;
`ifdef LPM_FIFO_DC_RDSIDE_CHECK_EN
      rderror <= 1'b0;
`endif
    end else begin
      rdptr_b <= next_rdptr_b;
      wr_b    <= next_wr_b;
      rdptr_g <= PTR_W'(bin2gray(FUNC_W'(next_rdptr_b)));
`ifdef LPM_FIFO_DC_RDSIDE_CHECK_EN
      rderror <= underflow | overflow;
      if (overflow) begin
        rdusedw <= DEPTH;
        rdempty <= 1'b0;
        rdfull  <= 1'b1;
      end else begin
        rdusedw <= next_used;
        rdempty <= (next_used == '0);
        rdfull  <= (next_used == DEPTH);
      end
`else
      rdusedw <= next_used;
      rdempty <= (next_used == '0);
      rdfull  <= (next_used == DEPTH);
`endif
    end
  end

`ifndef LPM_FIFO_DC_RDSIDE_CHECK_EN
  assign rderror = 1'b0;
`endif

endmodule
